// File: rtl/hazard_md_ctrl_pkg.sv
// Shared constants, MD sequencer state encoding and hazard helper functions
// for the MIPS pipeline hazard controller.
package hazard_md_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // A source must wait when a producer matching it will not have its
  // result ready by the time the source is consumed; $0 never waits.
  function automatic logic src_stall(input logic [4:0] addr, input logic [1:0] tuse,
                                     input logic [4:0] wreg, input logic [1:0] tnew);
    return (addr != 5'd0) && (tuse != TUSE_NONE) && (addr == wreg) && (tnew > tuse);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] addr,
                                         input logic [4:0] e_wreg, input logic [1:0] e_tnew,
                                         input logic [4:0] m_wreg, input logic [1:0] m_tnew);
    if ((addr != 5'd0) && (addr == e_wreg) && (e_tnew == 2'd0)) return FWD_E;
    if ((addr != 5'd0) && (addr == m_wreg) && (m_tnew == 2'd0)) return FWD_M;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_md_ctrl_md_busy_seq.sv
// HI/LO unit busy sequencer: counts the mult/div latency after a start and
// pulses o_done in the first idle cycle that follows.
module md_busy_seq
  import hazard_md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_is_div,
  output logic       o_busy,
  output logic       o_done,
  output md_state_e  o_state
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  // i_start is a single-cycle issue strobe with no ready: it is taken only
  // while IDLE; a start while BUSY is dropped (upstream stalls prevent it).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_count <= i_is_div ? DIV_LOAD : MULT_LOAD;
            r_state <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= MD_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_busy  = (r_state == MD_BUSY);
  assign o_done  = r_done;
  assign o_state = r_state;

endmodule

// File: rtl/hazard_md_ctrl.sv
// Central stall/flush/forward controller for the 5-stage MIPS pipeline,
// combining Tuse/Tnew data hazards with the HI/LO unit busy interlock.
module hazard_md_ctrl
  import hazard_md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_rs_tuse,
  input  logic [1:0] d_rt_tuse,
  input  logic       d_is_md,
  input  logic [4:0] e_wreg,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wreg,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_is_div,
  output logic       stall_pc,
  output logic       stall_fd,
  output logic       flush_de,
  output logic [1:0] fwd_rs_sel,
  output logic [1:0] fwd_rt_sel,
  output logic       md_busy,
  output logic       md_done
);

  logic      w_md_busy;
  logic      w_md_done;
  md_state_e w_md_state;
  logic      w_stall_rs;
  logic      w_stall_rt;
  logic      w_md_stall;
  logic      w_stall;

  md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_seq (
    .clk      (clk),
    .reset    (reset),
    .i_start  (e_md_start),
    .i_is_div (e_md_is_div),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_state  (w_md_state)
  );

  assign w_stall_rs = src_stall(d_rs_addr, d_rs_tuse, e_wreg, e_tnew)
                    | src_stall(d_rs_addr, d_rs_tuse, m_wreg, m_tnew);
  assign w_stall_rt = src_stall(d_rt_addr, d_rt_tuse, e_wreg, e_tnew)
                    | src_stall(d_rt_addr, d_rt_tuse, m_wreg, m_tnew);

  // A start in E also blocks, since the unit becomes busy on the next edge.
  assign w_md_stall = d_is_md & ((w_md_state == MD_BUSY) | e_md_start);
  assign w_stall    = w_stall_rs | w_stall_rt | w_md_stall;

  assign stall_pc   = w_stall;
  assign stall_fd   = w_stall;
  assign flush_de   = w_stall;
  assign fwd_rs_sel = fwd_sel(d_rs_addr, e_wreg, e_tnew, m_wreg, m_tnew);
  assign fwd_rt_sel = fwd_sel(d_rt_addr, e_wreg, e_tnew, m_wreg, m_tnew);
  assign md_busy    = w_md_busy;
  assign md_done    = w_md_done;

endmodule
